pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the pipelined core: successor to the fixed 16-bit PC block. It produces the instruction-memory address and redirects on taken branches and jumps. A registered one-cycle data-fetch override for LWI replaces the old combinational mux. It carries a parametrised chain of pipelined PC copies and a small return-address stack (RAS) for JAL/return prediction. It sits at the IM stage and feeds the instruction memory, the EX branch logic and the DM-stage destination mux.

## Interface
- PC_W, 16, PC and address width.
- RST_VEC, 0, reset/boot value of the fetch PC.
- PIPE_DEPTH, 3, number of pipelined PC copies (IM_ID, ID_EX, EX_DM, ...); minimum 1.
- RAS_DEPTH, 4, return-address stack entries; power of two, minimum 2.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  freeze fetch PC and stage 0 of the PC pipe.
- flow_change  in  1  taken branch/jump from EX.
- dst  in  PC_W  redirect target, valid with flow_change.
- ovr_req  in  1  LWI data-fetch request from DM.
- ovr_addr  in  PC_W  LWI data address, valid with ovr_req.
- ras_push  in  1  JAL in ID: push pc_pipe[0].
- ras_pop  in  1  return in ID: pop top.
- pc  out  PC_W  instruction-memory address.
- ovr_valid  out  1  high while pc carries an override address.
- pc_pipe  out  PIPE_DEPTH*PC_W  pipelined PC+1 copies; slice k is stage k.
- ras_top  out  PC_W  current RAS top (predicted return address).
- ras_empty  out  1  RAS holds no entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.

## Operation
- Internal fetch register pc_f; state machine states RUN and OVR.
- pc = ovr_q in OVR, else pc_f. ovr_valid = (state == OVR).
- RUN, ovr_req=1:
  - Capture ovr_addr into ovr_q and go to OVR.
  - pc_f does not advance this edge, regardless of stall.
  - A simultaneous flow_change still loads dst into pc_f.
- RUN, ovr_req=0, stall=0: pc_f <= flow_change ? dst : pc_f+1. Redirect beats increment.
- RUN, stall=1: pc_f holds. flow_change is ignored; the pipeline re-presents it.
- OVR:
  - Lasts exactly one cycle, then returns to RUN.
  - ovr_req=1 in OVR recaptures ovr_addr and stays in OVR (back-to-back LWI).
  - pc_f holds in OVR unless flow_change=1, which loads dst.
  - stall does not extend OVR.
- Increment wraps modulo 2^PC_W: all-ones+1 = 0.
- PC pipe:
  - Stage 0 loads pc_f+1 when stall=0 and state==RUN.
  - Stage k>0 loads stage k-1 every cycle, unconditionally.
- RAS: circular buffer with pointer sp and count cnt (0..RAS_DEPTH).
  - push only: write pc_pipe[0] at sp+1, sp++, cnt saturating increment.
  - push when full overwrites the oldest entry and keeps ras_full=1.
  - pop only, cnt>0: sp--, cnt--.
  - pop when empty: no state change.
  - push and pop together: overwrite top with pc_pipe[0]; sp and cnt unchanged (cnt becomes 1 if it was 0).
  - ras_top = entry[sp] when cnt>0, else RST_VEC.

## Timing
- Reset, asynchronous and immediate:
  - pc_f=RST_VEC, so pc=RST_VEC.
  - state=RUN, ovr_valid=0, ovr_q=0.
  - All pc_pipe stages=0.
  - sp=0, cnt=0, so ras_empty=1, ras_full=0, ras_top=RST_VEC.
- Reset asserted mid-OVR or mid-redirect discards the event; the first post-reset fetch is at RST_VEC.
- Redirect latency: flow_change sampled at edge N gives pc=dst after edge N.
- Override latency: ovr_req at edge N gives pc=ovr_addr and ovr_valid=1 for cycle N..N+1. pc resumes pc_f after edge N+1.
- Pipe latency: stage k reflects the fetch of k+1 edges earlier, absent stalls.
- RAS updates on the edge. ras_top, ras_empty and ras_full are combinational from registered state.
- All outputs glitch-free from registers, except the pc mux and ras_top mux.

## Test plan
- Reset then 4 free-run cycles -> pc 0,1,2,3,4; pc_pipe[0]=4 at cycle 4; pc_pipe[2]=2.
- pc=0x0005, flow_change=1, dst=0x0100, one edge -> pc=0x0100, then 0x0101. Same with stall=1 -> pc stays 0x0005.
- pc=0x0010, ovr_req=1, ovr_addr=0x8000 for 1 cycle -> pc=0x8000 with ovr_valid=1 for 1 cycle, then pc=0x0010, then 0x0011. Two consecutive ovr_req cycles (0x8000, 0x8001) -> ovr_valid high 2 cycles.
- pc=0xFFFF, free-run -> next pc=0x0000.
- 5 pushes of 0x11..0x15 into RAS_DEPTH=4 -> ras_full=1, ras_top=0x15. 4 pops -> 0x14, 0x13, 0x12, then ras_empty=1 and ras_top=RST_VEC. 5th pop -> no change. Push and pop together on an empty RAS -> cnt becomes 1.
- Assert rst_n=0 during OVR -> pc=RST_VEC immediately, ovr_valid=0, RAS empty.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the IM stage of the pipelined core.
// It produces the fetch address and applies redirects from EX. A registered
// one-cycle override carries LWI data addresses. It also provides a chain of
// pipelined PC+1 copies and a small circular return-address stack.
module pc_gen #(
   parameter int unsigned     PC_W       = 16,
   parameter logic [PC_W-1:0] RST_VEC    = '0,
   parameter int unsigned     PIPE_DEPTH = 3,
   parameter int unsigned     RAS_DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       stall,
   input  logic                       flow_change,
   input  logic [PC_W-1:0]            dst,
   input  logic                       ovr_req,
   input  logic [PC_W-1:0]            ovr_addr,
   input  logic                       ras_push,
   input  logic                       ras_pop,
   output logic [PC_W-1:0]            pc,
   output logic                       ovr_valid,
   output logic [PIPE_DEPTH*PC_W-1:0] pc_pipe,
   output logic [PC_W-1:0]            ras_top,
   output logic                       ras_empty,
   output logic                       ras_full
);

   localparam int unsigned SP_W  = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

   localparam logic [0:0] RUN = 1'b0;
   localparam logic [0:0] OVR = 1'b1;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Fetch state
   logic [0:0]      state_q, state_d;
   logic [PC_W-1:0] pc_f_q, pc_f_d;
   logic [PC_W-1:0] ovr_q, ovr_d;
   logic [PC_W-1:0] pc_inc;

   // PC pipe
   logic [PC_W-1:0] pipe_q [PIPE_DEPTH];

   // Return-address stack
   logic [PC_W-1:0]  ras_q [RAS_DEPTH];
   logic [SP_W-1:0]  sp_q, sp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ras_wr_en;
   logic [SP_W-1:0]  ras_wr_idx;

   // The increment wraps naturally at the PC width.
   assign pc_inc = pc_f_q + PC_W'(1);

   // Next fetch PC, override address and RUN/OVR state.
   always_comb begin
      state_d = state_q;
      pc_f_d  = pc_f_q;
      ovr_d   = ovr_q;
      case (state_q)
         RUN: begin
            if (ovr_req) begin
               state_d = OVR;
               ovr_d   = ovr_addr;
               if (flow_change) begin
                  pc_f_d = dst;
               end
            end else if (!stall) begin
               pc_f_d = flow_change ? dst : pc_inc;
            end
         end
         default: begin
            state_d = ovr_req ? OVR : RUN;
            if (ovr_req) begin
               ovr_d = ovr_addr;
            end
            if (flow_change) begin
               pc_f_d = dst;
            end
         end
      endcase
   end

   // Fetch registers. An asynchronous reset discards any pending override or redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         pc_f_q  <= RST_VEC;
         ovr_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_f_q  <= pc_f_d;
         ovr_q   <= ovr_d;
      end
   end

   // PC pipe: stage 0 follows fetch, later stages shift every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            pipe_q[k] <= '0;
         end
      end else begin
         if (!stall && state_q == RUN) begin
            pipe_q[0] <= pc_inc;
         end
         for (int k = 1; k < PIPE_DEPTH; k++) begin
            pipe_q[k] <= pipe_q[k-1];
         end
      end
   end

   // RAS pointer/count update and entry write selection.
   always_comb begin
      sp_d       = sp_q;
      cnt_d      = cnt_q;
      ras_wr_en  = 1'b0;
      ras_wr_idx = sp_q;
      case ({ras_push, ras_pop})
         2'b10: begin
            ras_wr_en  = 1'b1;
            ras_wr_idx = sp_q + SP_W'(1);
            sp_d       = sp_q + SP_W'(1);
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         2'b01: begin
            if (cnt_q != '0) begin
               sp_d  = sp_q - SP_W'(1);
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         2'b11: begin
            ras_wr_en  = 1'b1;
            ras_wr_idx = sp_q;
            if (cnt_q == '0) begin
               cnt_d = CNT_ONE;
            end
         end
         default: begin
            sp_d = sp_q;
         end
      endcase
   end

   // RAS registers. A full stack overwrites its oldest entry on push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_q[i] <= '0;
         end
      end else begin
         sp_q  <= sp_d;
         cnt_q <= cnt_d;
         if (ras_wr_en) begin
            ras_q[ras_wr_idx] <= pipe_q[0];
         end
      end
   end

   // Output muxes and flattening of the pipe copies.
   always_comb begin
      pc        = (state_q == OVR) ? ovr_q : pc_f_q;
      ovr_valid = (state_q == OVR);
      ras_empty = (cnt_q == '0);
      ras_full  = (cnt_q == CNT_MAX);
      ras_top   = (cnt_q != '0) ? ras_q[sp_q] : RST_VEC;
      pc_pipe   = '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
         pc_pipe[k*PC_W +: PC_W] = pipe_q[k];
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen. The driver updates a behavioural model
// and queues the expected outputs. The monitor pops and compares them after each edge.
module tb_pc_gen;

   localparam int unsigned PC_W       = 16;
   localparam int unsigned PIPE_DEPTH = 3;
   localparam int unsigned RAS_DEPTH  = 4;
   localparam logic [PC_W-1:0] RST_VEC = '0;
   localparam int unsigned PC_MOD     = 1 << PC_W;

   logic                       clk;
   logic                       rst_n;
   logic                       stall;
   logic                       flow_change;
   logic [PC_W-1:0]            dst;
   logic                       ovr_req;
   logic [PC_W-1:0]            ovr_addr;
   logic                       ras_push;
   logic                       ras_pop;
   logic [PC_W-1:0]            pc;
   logic                       ovr_valid;
   logic [PIPE_DEPTH*PC_W-1:0] pc_pipe;
   logic [PC_W-1:0]            ras_top;
   logic                       ras_empty;
   logic                       ras_full;

   typedef struct {
      logic [PC_W-1:0]            pc;
      logic                       ovrValid;
      logic [PIPE_DEPTH*PC_W-1:0] pipe;
      logic [PC_W-1:0]            top;
      logic                       empty;
      logic                       full;
   } expT;

   expT expQ[$];
   event sampleEv;

   int total = 0;
   int bad   = 0;
   int pushedCount  = 0;
   int checkedCount = 0;

   // Behavioural model state
   int unsigned modelPcF;
   bit          modelInOvr;
   int unsigned modelOvrAddr;
   int unsigned pipeQ[$];
   int unsigned rasQ[$];

   pc_gen #(
      .PC_W(PC_W),
      .RST_VEC(RST_VEC),
      .PIPE_DEPTH(PIPE_DEPTH),
      .RAS_DEPTH(RAS_DEPTH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .stall(stall),
      .flow_change(flow_change),
      .dst(dst),
      .ovr_req(ovr_req),
      .ovr_addr(ovr_addr),
      .ras_push(ras_push),
      .ras_pop(ras_pop),
      .pc(pc),
      .ovr_valid(ovr_valid),
      .pc_pipe(pc_pipe),
      .ras_top(ras_top),
      .ras_empty(ras_empty),
      .ras_full(ras_full)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Queue the model's view of the outputs
   task automatic pushExpected();
      expT e;
      e.pc       = PC_W'(modelInOvr ? modelOvrAddr : modelPcF);
      e.ovrValid = modelInOvr;
      e.pipe     = '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
         e.pipe[k*PC_W +: PC_W] = PC_W'(pipeQ[k]);
      end
      e.top   = (rasQ.size() > 0) ? PC_W'(rasQ[rasQ.size()-1]) : RST_VEC;
      e.empty = (rasQ.size() == 0);
      e.full  = (rasQ.size() == RAS_DEPTH);
      expQ.push_back(e);
      pushedCount++;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Assert reset mid-cycle and leave it held; the next stimulus releases it
   task automatic applyReset();
      @(negedge clk);
      #2;
      rst_n       = 1'b0;
      stall       = 1'b0;
      flow_change = 1'b0;
      ovr_req     = 1'b0;
      ras_push    = 1'b0;
      ras_pop     = 1'b0;
      modelPcF     = RST_VEC;
      modelInOvr   = 1'b0;
      modelOvrAddr = 0;
      pipeQ.delete();
      for (int k = 0; k < PIPE_DEPTH; k++) pipeQ.push_back(0);
      rasQ.delete();
      pushExpected();
      ->sampleEv;
      @(posedge clk);
   endtask

   // Drive one cycle of inputs and advance the model across the coming edge
   task automatic applyStimulus(input bit st, input bit fc, input int unsigned d,
                                input bit oreq, input int unsigned oa,
                                input bit pu, input bit po);
      int unsigned stage0New;
      int unsigned pushVal;
      @(negedge clk);
      rst_n       = 1'b1;
      stall       = st;
      flow_change = fc;
      dst         = PC_W'(d);
      ovr_req     = oreq;
      ovr_addr    = PC_W'(oa);
      ras_push    = pu;
      ras_pop     = po;

      stage0New = (!st && !modelInOvr) ? (modelPcF + 1) % PC_MOD : pipeQ[0];
      pushVal   = pipeQ[0];

      if (pu && po) begin
         if (rasQ.size() == 0) rasQ.push_back(pushVal);
         else rasQ[rasQ.size()-1] = pushVal;
      end else if (pu) begin
         rasQ.push_back(pushVal);
         if (rasQ.size() > RAS_DEPTH) void'(rasQ.pop_front());
      end else if (po) begin
         if (rasQ.size() > 0) void'(rasQ.pop_back());
      end

      pipeQ.push_front(stage0New);
      void'(pipeQ.pop_back());

      if (modelInOvr) begin
         if (fc) modelPcF = d % PC_MOD;
         modelInOvr = oreq;
         if (oreq) modelOvrAddr = oa % PC_MOD;
      end else if (oreq) begin
         if (fc) modelPcF = d % PC_MOD;
         modelInOvr   = 1'b1;
         modelOvrAddr = oa % PC_MOD;
      end else if (!st) begin
         modelPcF = fc ? d % PC_MOD : (modelPcF + 1) % PC_MOD;
      end

      pushExpected();
   endtask

   // Monitor: compare after each edge, or right after an asynchronous reset
   initial begin
      expT e;
      forever begin
         @(posedge clk or sampleEv);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkedCount++;
            checkOutput("pc",        64'(pc),        64'(e.pc));
            checkOutput("ovr_valid", 64'(ovr_valid), 64'(e.ovrValid));
            checkOutput("pc_pipe",   64'(pc_pipe),   64'(e.pipe));
            checkOutput("ras_top",   64'(ras_top),   64'(e.top));
            checkOutput("ras_empty", 64'(ras_empty), 64'(e.empty));
            checkOutput("ras_full",  64'(ras_full),  64'(e.full));
         end
      end
   end

   initial begin
      int waitCycles;
      rst_n       = 1'b1;
      stall       = 1'b0;
      flow_change = 1'b0;
      dst         = '0;
      ovr_req     = 1'b0;
      ovr_addr    = '0;
      ras_push    = 1'b0;
      ras_pop     = 1'b0;

      $display("[TB] reset and free run");
      applyReset();
      repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0);

      $display("[TB] redirect and stalled redirect");
      applyStimulus(0, 1, 16'h0005, 0, 0, 0, 0);
      applyStimulus(0, 1, 16'h0100, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 16'h0005, 0, 0, 0, 0);
      applyStimulus(1, 1, 16'h0100, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);

      $display("[TB] override single and back-to-back");
      applyStimulus(0, 1, 16'h0010, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 16'h8000, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 16'h8000, 0, 0);
      applyStimulus(1, 0, 0, 1, 16'h8001, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 16'h0200, 1, 16'h9000, 0, 0);
      applyStimulus(0, 1, 16'h0300, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);

      $display("[TB] wrap");
      applyStimulus(0, 1, 16'hFFFF, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);

      $display("[TB] return-address stack");
      applyStimulus(0, 1, 16'h0010, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      repeat (5) applyStimulus(0, 0, 0, 0, 0, 1, 0);
      repeat (5) applyStimulus(1, 0, 0, 0, 0, 0, 1);
      applyStimulus(1, 0, 0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);

      $display("[TB] reset during override");
      applyStimulus(0, 1, 16'h0040, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 16'h8123, 1, 0);
      applyReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);

      $display("[TB] random phase");
      for (int i = 0; i < 2000; i++) begin
         int unsigned d;
         if ($urandom_range(0, 199) == 0) begin
            applyReset();
         end else begin
            d = ($urandom_range(0, 3) == 0) ? (PC_MOD - 1 - $urandom_range(0, 3)) : $urandom_range(0, PC_MOD - 1);
            applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0, d,
                          $urandom_range(0, 6) == 0, $urandom_range(0, PC_MOD - 1),
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
         end
      end

      // Drain the scoreboard with a bounded wait
      waitCycles = 0;
      while (expQ.size() > 0 && waitCycles < 20) begin
         @(posedge clk);
         waitCycles++;
      end
      #2;
      total++;
      if (expQ.size() != 0 || checkedCount != pushedCount) begin
         bad++;
         $display("[TB] FAIL drain: checked %0d of %0d expected entries", checkedCount, pushedCount);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
